// File: rtl/cdc_pkg.sv
// Shared constants and helpers for the clock-domain-crossing blocks.
//   CDC_SYNC_STAGES_*   : default and legal range of synchronizer depth
//   CDC_STABLE_CYCLES_* : default and legal range of the stability filter window
//   cdc_cnt_width()     : width of the stability counter for a given window
package cdc_pkg;

  localparam int unsigned CDC_SYNC_STAGES_DEF   = 2;
  localparam int unsigned CDC_SYNC_STAGES_MIN   = 2;
  localparam int unsigned CDC_SYNC_STAGES_MAX   = 4;

  localparam int unsigned CDC_STABLE_CYCLES_DEF = 4;
  localparam int unsigned CDC_STABLE_CYCLES_MIN = 1;
  localparam int unsigned CDC_STABLE_CYCLES_MAX = 255;

  // max(1, clog2(n)): the counter only ever reaches n-1, so it never wraps.
  function automatic int unsigned cdc_cnt_width(input int unsigned stable_cycles);
    return (stable_cycles > 2) ? $clog2(stable_cycles) : 1;
  endfunction

endpackage

// File: rtl/cdc_sync_chain.sv
// Multi-flop synchronizer for one asynchronous bit.
//   clk   : destination clock
//   rst_n : asynchronous active-low reset, loads RESET_VALUE into every stage
//   d     : asynchronous input bit
//   q     : synchronized output (last stage)
module cdc_sync_chain
  import cdc_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = CDC_SYNC_STAGES_DEF,
  parameter logic        RESET_VALUE = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  if (SYNC_STAGES < CDC_SYNC_STAGES_MIN || SYNC_STAGES > CDC_SYNC_STAGES_MAX) begin : gen_bad_stages
    $error("cdc_sync_chain: SYNC_STAGES out of legal range 2..4");
  end

  // Pure flop chain: nothing may be placed between stages, and the tools must
  // keep the flops adjacent so metastability has a full cycle to resolve.
  (* ASYNC_REG = "TRUE", dont_touch = "true" *) logic [SYNC_STAGES-1:0] sync_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= {SYNC_STAGES{RESET_VALUE}};
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], d};
    end
  end

  assign q = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/cdc_bit_synchronizer.sv
// Single-bit CDC receiver: synchronizer chain, stability filter and edge strobes.
//   clk           : clock for all logic
//   rst_n         : asynchronous active-low reset (deassertion synchronous to clk)
//   data_in       : asynchronous level input
//   data_out_fast : synchronized copy of data_in
//   data_out_slow : debounced copy of data_out_fast
//   rise_pulse    : one-cycle strobe on 0->1 of data_out_fast
//   fall_pulse    : one-cycle strobe on 1->0 of data_out_fast
module cdc_bit_synchronizer
  import cdc_pkg::*;
#(
  parameter int unsigned SYNC_STAGES   = CDC_SYNC_STAGES_DEF,
  parameter int unsigned STABLE_CYCLES = CDC_STABLE_CYCLES_DEF,
  parameter logic        RESET_VALUE   = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic data_in,
  output logic data_out_fast,
  output logic data_out_slow,
  output logic rise_pulse,
  output logic fall_pulse
);

  if (STABLE_CYCLES < CDC_STABLE_CYCLES_MIN ||
      STABLE_CYCLES > CDC_STABLE_CYCLES_MAX) begin : gen_bad_stable
    $error("cdc_bit_synchronizer: STABLE_CYCLES out of legal range 1..255");
  end

  localparam int unsigned     CNT_W    = cdc_cnt_width(STABLE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

  logic             fast;
  logic             prev_q;
  logic             slow_q, slow_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  cdc_sync_chain #(
    .SYNC_STAGES (SYNC_STAGES),
    .RESET_VALUE (RESET_VALUE)
  ) u_sync_chain (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (data_in),
    .q     (fast)
  );

  // cnt counts consecutive cycles of disagreement; any agreement restarts it,
  // so only a change held for the whole window reaches the slow output.
  always_comb begin
    slow_d = slow_q;
    cnt_d  = cnt_q;
    if (fast == slow_q) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_LAST) begin
      slow_d = fast;
      cnt_d  = '0;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_q <= RESET_VALUE;
      slow_q <= RESET_VALUE;
      cnt_q  <= '0;
    end else begin
      prev_q <= fast;
      slow_q <= slow_d;
      cnt_q  <= cnt_d;
    end
  end

  // Both operands are flop outputs, so the strobes are glitch-free.
  assign data_out_fast = fast;
  assign data_out_slow = slow_q;
  assign rise_pulse    = fast & ~prev_q;
  assign fall_pulse    = ~fast & prev_q;

endmodule

// File: tb/tb_cdc_bit_synchronizer.sv
module tb_cdc_bit_synchronizer;

  localparam int unsigned SS_A = 2, ST_A = 4;
  localparam int unsigned SS_B = 3, ST_B = 1;
  localparam logic        RV   = 1'b0;

  logic clk, rst_n;
  logic data_in_a, data_in_b;
  logic fast_a, slow_a, rise_a, fall_a;
  logic fast_b, slow_b, rise_b, fall_b;

  cdc_bit_synchronizer #(
    .SYNC_STAGES(SS_A), .STABLE_CYCLES(ST_A), .RESET_VALUE(RV)
  ) dut_a (
    .clk(clk), .rst_n(rst_n), .data_in(data_in_a),
    .data_out_fast(fast_a), .data_out_slow(slow_a),
    .rise_pulse(rise_a), .fall_pulse(fall_a)
  );

  cdc_bit_synchronizer #(
    .SYNC_STAGES(SS_B), .STABLE_CYCLES(ST_B), .RESET_VALUE(RV)
  ) dut_b (
    .clk(clk), .rst_n(rst_n), .data_in(data_in_b),
    .data_out_fast(fast_b), .data_out_slow(slow_b),
    .rise_pulse(rise_b), .fall_pulse(fall_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic fast_o [2], slow_o [2], rise_o [2], fall_o [2];
  assign fast_o[0] = fast_a; assign slow_o[0] = slow_a;
  assign rise_o[0] = rise_a; assign fall_o[0] = fall_a;
  assign fast_o[1] = fast_b; assign slow_o[1] = slow_b;
  assign rise_o[1] = rise_b; assign fall_o[1] = fall_b;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: fast is data_in delayed by the sync depth; slow flips when
  // the last STABLE pre-edge fast samples all disagree with it.
  int unsigned ss [2] = '{SS_A, SS_B};
  int unsigned st [2] = '{ST_A, ST_B};
  bit hist [2][8];
  bit win  [2][8];
  bit m_fast [2], m_slow [2], m_rise [2], m_fall [2];
  int m_rises [2], m_falls [2];

  logic drive [2];
  int rise_seen [2], fall_seen [2], fast_hi [2], slow_hi [2], slow_lo [2];

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < 8; i++) begin
        hist[k][i] = RV;
        win[k][i]  = RV;
      end
      m_fast[k] = RV; m_slow[k] = RV; m_rise[k] = 1'b0; m_fall[k] = 1'b0;
    end
  endtask

  task automatic model_edge(input int k, input bit d);
    bit fast_pre, slow_pre, all_diff;
    fast_pre = m_fast[k];
    slow_pre = m_slow[k];
    for (int i = 7; i > 0; i--) win[k][i] = win[k][i-1];
    win[k][0] = fast_pre;
    all_diff = 1'b1;
    for (int i = 0; i < int'(st[k]); i++) if (win[k][i] == slow_pre) all_diff = 1'b0;
    if (all_diff) m_slow[k] = ~slow_pre;
    for (int i = 7; i > 0; i--) hist[k][i] = hist[k][i-1];
    hist[k][0] = d;
    m_fast[k] = hist[k][ss[k]-1];
    m_rise[k] = m_fast[k] & ~fast_pre;
    m_fall[k] = ~m_fast[k] & fast_pre;
    if (m_rise[k]) m_rises[k]++;
    if (m_fall[k]) m_falls[k]++;
  endtask

  task automatic check(input string tag, input logic obs, input logic exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic check_int(input string tag, input int obs, input int lo, input int hi);
    n_cmp++;
    assert (obs >= lo && obs <= hi) else begin
      n_bad++;
      $error("FAIL %s observed=%0d expected=%0d..%0d", tag, obs, lo, hi);
    end
  endtask

  task automatic check_all(input string tag);
    for (int k = 0; k < 2; k++) begin
      check($sformatf("%s_fast%0d", tag, k), fast_o[k], m_fast[k]);
      check($sformatf("%s_slow%0d", tag, k), slow_o[k], m_slow[k]);
      check($sformatf("%s_rise%0d", tag, k), rise_o[k], m_rise[k]);
      check($sformatf("%s_fall%0d", tag, k), fall_o[k], m_fall[k]);
      check($sformatf("%s_overlap%0d", tag, k), rise_o[k] & fall_o[k], 1'b0);
    end
  endtask

  task automatic clear_stats();
    for (int k = 0; k < 2; k++) begin
      rise_seen[k] = 0; fall_seen[k] = 0; fast_hi[k] = 0; slow_hi[k] = 0; slow_lo[k] = 0;
      m_rises[k] = 0; m_falls[k] = 0;
    end
  endtask

  // One clock: apply inputs, step the model at the edge, compare 1 ns later.
  task automatic tick(input string tag);
    data_in_a = drive[0];
    data_in_b = drive[1];
    @(posedge clk);
    if (rst_n) begin
      model_edge(0, drive[0]);
      model_edge(1, drive[1]);
    end
    #1;
    check_all(tag);
    for (int k = 0; k < 2; k++) begin
      rise_seen[k] += int'(rise_o[k]);
      fall_seen[k] += int'(fall_o[k]);
      fast_hi[k]   += int'(fast_o[k]);
      slow_hi[k]   += int'(slow_o[k]);
      slow_lo[k]   += int'(!slow_o[k]);
    end
  endtask

  task automatic until_fast(input int k, input logic v, input int limit, output int n);
    n = 0;
    while (fast_o[k] !== v && n < limit) begin
      tick("wait_fast");
      n++;
    end
  endtask

  task automatic until_slow(input int k, input logic v, input int limit, output int n);
    n = 0;
    while (slow_o[k] !== v && n < limit) begin
      tick("wait_slow");
      n++;
    end
  endtask

  int n, m;
  int run_len [2];

  initial begin
    // 1: reset with data_in high, then release
    rst_n = 1'b0;
    drive[0] = 1'b1; drive[1] = 1'b1;
    data_in_a = 1'b1; data_in_b = 1'b1;
    model_reset();
    #1;
    check_all("s1_rst");
    repeat (3) tick("s1_rst");
    rst_n = 1'b1;
    clear_stats();
    until_fast(0, 1'b1, 8, n);
    check_int("s1_fast_lat", n, SS_A, SS_A + 1);
    until_slow(0, 1'b1, 8, m);
    check_int("s1_slow_after_fast", m, ST_A, ST_A);
    check_int("s1_rise_count", rise_seen[0], 1, 1);

    // 2: clean 0->1 step held 100 ns
    drive[0] = 1'b0; drive[1] = 1'b0;
    repeat (10) tick("s2_settle");
    clear_stats();
    drive[0] = 1'b1;
    until_fast(0, 1'b1, 8, n);
    check_int("s2_fast_lat", n, SS_A, SS_A + 1);
    until_slow(0, 1'b1, 8, m);
    check_int("s2_slow_after_fast", m, ST_A, ST_A);
    repeat (4) tick("s2_hold");
    check_int("s2_rise_count", rise_seen[0], 1, 1);
    check_int("s2_fall_count", fall_seen[0], 0, 0);

    // 3: 3-cycle high pulse is filtered out
    drive[0] = 1'b0;
    repeat (10) tick("s3_settle");
    clear_stats();
    drive[0] = 1'b1;
    repeat (3) tick("s3_pulse");
    drive[0] = 1'b0;
    repeat (12) tick("s3_after");
    check_int("s3_slow_high_cycles", slow_hi[0], 0, 0);
    check_int("s3_fast_high_cycles", fast_hi[0], 3, 3);
    check_int("s3_rise_count", rise_seen[0], 1, 1);
    check_int("s3_fall_count", fall_seen[0], 1, 1);

    // 4: 2-cycle low dropout while high is filtered out
    drive[0] = 1'b1;
    repeat (10) tick("s4_settle");
    clear_stats();
    drive[0] = 1'b0;
    repeat (2) tick("s4_drop");
    drive[0] = 1'b1;
    repeat (12) tick("s4_after");
    check_int("s4_slow_low_cycles", slow_lo[0], 0, 0);
    check_int("s4_fall_count", fall_seen[0], 1, 1);
    check_int("s4_rise_count", rise_seen[0], 1, 1);

    // 5: reset mid-window restarts the full latency
    drive[0] = 1'b0;
    repeat (10) tick("s5_settle");
    drive[0] = 1'b1;
    until_fast(0, 1'b1, 8, n);
    repeat (2) tick("s5_window");
    check("s5_slow_before_rst", slow_o[0], 1'b0);
    rst_n = 1'b0;
    model_reset();
    #1;
    check_all("s5_rst_now");
    repeat (2) tick("s5_rst");
    rst_n = 1'b1;
    until_slow(0, 1'b1, 12, m);
    check_int("s5_full_latency", m, SS_A + ST_A, SS_A + ST_A + 1);

    // 6: second configuration (3 stages, 1-cycle filter)
    drive[1] = 1'b0;
    repeat (10) tick("s6_settle");
    clear_stats();
    drive[1] = 1'b1;
    until_fast(1, 1'b1, 8, n);
    check_int("s6_fast_lat", n, SS_B, SS_B + 1);
    until_slow(1, 1'b1, 8, m);
    check_int("s6_slow_after_fast", m, ST_B, ST_B);
    check_int("s6_rise_count", rise_seen[1], 1, 1);

    // Random toggling on both instances with mixed run lengths
    clear_stats();
    run_len[0] = 1; run_len[1] = 1;
    for (int c = 0; c < 10000; c++) begin
      for (int k = 0; k < 2; k++) begin
        run_len[k]--;
        if (run_len[k] == 0) begin
          drive[k] = ~drive[k];
          run_len[k] = int'($urandom_range(1, 8));
        end
      end
      tick("rnd");
    end
    for (int k = 0; k < 2; k++) begin
      check_int($sformatf("rnd_rise_count%0d", k), rise_seen[k], m_rises[k], m_rises[k]);
      check_int($sformatf("rnd_fall_count%0d", k), fall_seen[k], m_falls[k], m_falls[k]);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
